// File: rtl/fft_frame_feeder.sv
// Streams a recorded sample buffer into an FFT core as NUM_FRAMES evenly spaced frames of FRAME_LEN beats.
// Build option: define FEEDER_SIGNED_CONVERT_EN to convert offset-binary samples to two's complement.
module fft_frame_feeder #(
  parameter int FRAME_LEN  = 2048,
  parameter int NUM_FRAMES = 4,
  parameter int ADDR_W     = 17,
  localparam int FL_W      = $clog2(FRAME_LEN),
  localparam int NF_SH     = $clog2(NUM_FRAMES),
  localparam int FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] rec_length_in,
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic              rd_en_out,
  input  logic [7:0]        rd_data_in,
  output logic              m_axis_tvalid,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy_out,
  output logic              done_out,
  output logic [FI_W-1:0]   frame_idx_out,
  output logic [1:0]        state_dbg_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] len_q, hop_q, base_q;
  logic [FL_W-1:0]   cnt_q;
  logic [FI_W-1:0]   frame_q;
  logic              s1_vld_q, s1_pad_q, s1_last_q;
  logic              s2_vld_q, s2_pad_q, s2_last_q;
  logic [8:0]        fifo_q [4];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        occ_q;
  logic              done_q, busy_q;

  logic [ADDR_W:0]   addr_sum_d;
  logic              slot_pad_d, slot_last_d, issue_d, push_d, pop_d;
  logic [2:0]        credit_use_d;
  logic [7:0]        sample_d, wr_sample_d;
  logic [8:0]        head_d;

  // One extra carry bit catches base+counter wrapping past the address space.
  assign addr_sum_d   = {1'b0, base_q} + {{(ADDR_W + 1 - FL_W){1'b0}}, cnt_q};
  assign slot_pad_d   = addr_sum_d[ADDR_W] | (addr_sum_d[ADDR_W-1:0] >= len_q);
  assign slot_last_d  = (cnt_q == FL_W'(FRAME_LEN - 1));
  assign credit_use_d = occ_q + {2'b00, s1_vld_q} + {2'b00, s2_vld_q};
  assign issue_d      = (state_q == S_ISSUE) && (credit_use_d < 3'd4);

  assign rd_en_out    = issue_d & ~slot_pad_d;
  assign rd_addr_out  = issue_d ? addr_sum_d[ADDR_W-1:0] : '0;

`ifdef FEEDER_SIGNED_CONVERT_EN
  assign sample_d = {~rd_data_in[7], rd_data_in[6:0]};
`else
  assign sample_d = rd_data_in;
`endif
  assign wr_sample_d = s2_pad_q ? 8'h00 : sample_d;

  // AXIS: a beat transfers on a cycle where tvalid and tready are both high;
  // tvalid/tdata/tlast come from the FIFO head and only move on a transfer.
  assign head_d        = fifo_q[rd_ptr_q];
  assign m_axis_tvalid = (occ_q != 3'd0);
  assign m_axis_tdata  = m_axis_tvalid ? {head_d[7:0], 8'h00, 16'h0000} : 32'h0;
  assign m_axis_tlast  = m_axis_tvalid & head_d[8];
  assign push_d        = s2_vld_q;
  assign pop_d         = m_axis_tvalid & m_axis_tready;

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign frame_idx_out = frame_q;
  assign state_dbg_out = state_q;

  always_ff @(posedge clk_in) begin
    if (push_d) fifo_q[wr_ptr_q] <= {s2_last_q, wr_sample_d};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      hop_q     <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      frame_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_pad_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_pad_q  <= 1'b0;
      s2_last_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      s1_vld_q  <= issue_d;
      s1_pad_q  <= slot_pad_d;
      s1_last_q <= slot_last_d;
      s2_vld_q  <= s1_vld_q;
      s2_pad_q  <= s1_pad_q;
      s2_last_q <= s1_last_q;
      if (push_d) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop_d)  rd_ptr_q <= rd_ptr_q + 2'd1;
      occ_q <= occ_q + {2'b00, push_d} - {2'b00, pop_d};

      case (state_q)
        S_IDLE: begin
          // A start landing on the done pulse belongs to the finished run.
          if (start_in && !done_q) begin
            len_q   <= rec_length_in;
            hop_q   <= rec_length_in >> NF_SH;
            base_q  <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_d) begin
            if (slot_last_d) begin
              cnt_q  <= '0;
              base_q <= base_q + hop_q;
              if (frame_q == FI_W'(NUM_FRAMES - 1)) state_q <= S_DRAIN;
              else frame_q <= frame_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (occ_q == 3'd0 && !s1_vld_q && !s2_vld_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: random backpressure, a memory responder, and a frame-level reference
// model that fills an expected-beat queue popped by an independent output monitor.
module tb_fft_frame_feeder;
  localparam int FL       = 2048;
  localparam int NF       = 4;
  localparam int AW       = 17;
  localparam int MAX_ADDR = (1 << AW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_in, start_in;
  logic [AW-1:0] rec_length_in, rd_addr_out;
  logic          rd_en_out;
  logic [7:0]    rd_data_in;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0]   m_axis_tdata;
  logic          busy_out, done_out;
  logic [1:0]    frame_idx_out, state_dbg_out;

  fft_frame_feeder #(.FRAME_LEN(FL), .NUM_FRAMES(NF), .ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .rec_length_in(rec_length_in),
    .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy_out(busy_out), .done_out(done_out),
    .frame_idx_out(frame_idx_out), .state_dbg_out(state_dbg_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];  // {pad, last, tdata}
  int n_checks = 0, n_pass = 0;
  int ready_pct = 100, probe_run = 0;
  int rd_cnt, nonpad_acc, beat_cnt, done_cnt, first_rd, first_tv, max_out, exp_reads, start_cyc;
  logic [7:0] mem_xor = 8'h00;
  logic prev_stall = 1'b0, prev_last;
  logic [31:0] prev_data;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] mem_byte(input int a);
    return a[7:0] ^ mem_xor;
  endfunction

  function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef FEEDER_SIGNED_CONVERT_EN
    return b ^ 8'h80;
`else
    return b;
`endif
  endfunction

  // Reference model: frame f starts at f*(len/NF); addresses at or past len are zero pads.
  task automatic model_run(input int len);
    int hop;
    hop = len / NF;
    exp_reads = 0;
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < FL; i++) begin
        int a;
        bit pad;
        logic [7:0] b;
        a = f * hop + i;
        pad = (a >= len) || (a > MAX_ADDR);
        b = pad ? 8'h00 : conv(mem_byte(a));
        if (!pad) exp_reads++;
        exp_q.push_back({pad, (i == FL - 1), b, 8'h00, 16'h0000});
      end
    end
  endtask

  // ---------------- memory responder: data two cycles after the read ----------------
  initial begin
    logic [AW-1:0] cap_a, p1_a;
    logic cap_en, p1_en;
    rd_data_in = 8'h00;
    p1_a = '0;
    p1_en = 1'b0;
    forever begin
      @(negedge clk_in);
      cap_a = rd_addr_out;
      cap_en = rd_en_out;
      @(posedge clk_in);
      #1;
      rd_data_in = p1_en ? mem_byte(int'(p1_a)) : 8'($urandom);
      p1_a = cap_a;
      p1_en = cap_en;
    end
  end

  // ---------------- backpressure driver ----------------
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      m_axis_tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_stall = 1'b0;
    end else begin
      logic [33:0] e;
      if (rd_en_out) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (prev_stall)
        chk(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last, "stall_stable",
            {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_last, prev_data});
      if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        if (probe_run == 1 && beat_cnt == 2 * FL)
          chk(m_axis_tdata == {conv(8'h00), 24'h0}, "frame2_first_beat", m_axis_tdata, {conv(8'h00), 24'h0});
        if (probe_run == 2 && beat_cnt == 1000)
          chk(m_axis_tdata == 32'h0, "pad_beat_1000", m_axis_tdata, 0);
        if (probe_run == 2 && beat_cnt == FL)
          chk(m_axis_tdata == {conv(8'd250), 24'h0}, "frame1_first_beat", m_axis_tdata, {conv(8'd250), 24'h0});
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", {m_axis_tlast, m_axis_tdata}, 0);
        end else begin
          e = exp_q.pop_front();
          chk({m_axis_tlast, m_axis_tdata} == e[32:0], "beat", {m_axis_tlast, m_axis_tdata}, e[32:0]);
          if (!e[33]) nonpad_acc++;
        end
        beat_cnt++;
      end
      if (rd_cnt - nonpad_acc > max_out) max_out = rd_cnt - nonpad_acc;
      if (done_out) begin
        done_cnt++;
        chk(!busy_out, "busy_falls_with_done", busy_out, 0);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_run_stats();
    rd_cnt = 0; nonpad_acc = 0; beat_cnt = 0; done_cnt = 0;
    first_rd = -1; first_tv = -1; max_out = 0;
  endtask

  task automatic start_run(input int len);
    @(posedge clk_in); #1;
    start_in = 1'b1;
    rec_length_in = AW'(len);
    start_cyc = cyc;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    chk(busy_out, "busy_rise", busy_out, 1);
    chk(frame_idx_out == 2'd0, "start_frame_idx", frame_idx_out, 0);
    chk(rd_addr_out == '0, "start_addr", rd_addr_out, 0);
    chk(rd_en_out == (len > 0), "start_rd_en", rd_en_out, (len > 0));
  endtask

  task automatic run(input int len, input int pct, input bit poke_busy, input bit poke_done);
    bit got;
    ready_pct = pct;
    clear_run_stats();
    model_run(len);
    start_run(len);
    got = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk_in); #1;
      if (done_out) begin
        got = 1'b1;
        break;
      end
      if (poke_busy && i == 100) begin
        chk(busy_out, "busy_mid_run", busy_out, 1);
        start_in = 1'b1;
        rec_length_in = AW'($urandom_range(0, MAX_ADDR));
      end else begin
        start_in = 1'b0;
      end
    end
    start_in = 1'b0;
    chk(got, "done_timeout", got, 1);
    if (got && pct == 100) chk(cyc - start_cyc == NF * FL + 5, "done_latency", cyc - start_cyc, NF * FL + 5);
    if (poke_done) begin
      start_in = 1'b1;
      rec_length_in = AW'(64);
      @(posedge clk_in); #1;
      start_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk(!busy_out && !rd_en_out, "start_at_done_ignored", {busy_out, rd_en_out}, 0);
        @(posedge clk_in); #1;
      end
    end else begin
      repeat (3) @(posedge clk_in);
      #1;
    end
    chk(exp_q.size() == 0, "beats_left", exp_q.size(), 0);
    chk(done_cnt == 1, "done_pulses", done_cnt, 1);
    chk(max_out <= 4, "credit_limit", max_out, 4);
    chk(rd_cnt == exp_reads, "read_count", rd_cnt, exp_reads);
    if (len > 0) begin
      chk(first_rd - start_cyc == 1, "start_to_rd_en", first_rd - start_cyc, 1);
      chk(first_tv - first_rd == 3, "rd_to_tvalid", first_tv - first_rd, 3);
    end
    exp_q.delete();
  endtask

  task automatic reset_mid_run();
    bit reached;
    ready_pct = 70;
    clear_run_stats();
    model_run(8192);
    start_run(8192);
    reached = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk_in); #1;
      if (beat_cnt >= FL + 1500) begin
        reached = 1'b1;
        break;
      end
    end
    chk(reached, "reach_frame1_beat1500", beat_cnt, FL + 1500);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk(!m_axis_tvalid, "tvalid_after_reset", m_axis_tvalid, 0);
    chk(!busy_out && !done_out, "busy_done_after_reset", {busy_out, done_out}, 0);
    chk(frame_idx_out == 2'd0, "frame_idx_after_reset", frame_idx_out, 0);
    chk(!rd_en_out, "rd_en_after_reset", rd_en_out, 0);
    rst_in = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk_in);
    #1;
    chk(!m_axis_tvalid, "no_stale_beats", m_axis_tvalid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_in = 1'b1;
    start_in = 1'b0;
    rec_length_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk(!m_axis_tvalid && !m_axis_tlast, "reset_tvalid_tlast", {m_axis_tvalid, m_axis_tlast}, 0);
    chk(m_axis_tdata == 32'h0, "reset_tdata", m_axis_tdata, 0);
    chk(!rd_en_out && rd_addr_out == '0, "reset_rd", {rd_en_out, rd_addr_out}, 0);
    chk(!busy_out && !done_out, "reset_busy_done", {busy_out, done_out}, 0);
    chk(frame_idx_out == 2'd0 && state_dbg_out == 2'd0, "reset_idx_state", {frame_idx_out, state_dbg_out}, 0);
    rst_in = 1'b0;

    mem_xor = 8'h00;
    probe_run = 1;
    run(8192, 100, 1'b0, 1'b1);
    probe_run = 2;
    run(1000, 50, 1'b1, 1'b0);
    probe_run = 0;
    mem_xor = 8'($urandom);
    reset_mid_run();
    run(8192, 50, 1'b0, 1'b0);
    run(0, 100, 1'b0, 1'b0);
    mem_xor = 8'($urandom);
    run(3, 80, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
